ib_buffer: RTL

IB_BUFFER -- requirements
Module: ib_buffer

---
 rtl/ib_buffer.sv | 102 ++++++++++
 1 files changed

// File: rtl/ib_buffer.sv
// rtl/ib_buffer.sv - 8-byte circular I-stream prefetch buffer with fill, consume and flush
// Optional fill-to-output bypass when the buffer is empty: define IB_BYPASS_EN.
module ib_buffer (
  input  logic        clk_h,
  input  logic        reset_l,
  input  logic [1:0]  isize_l,
  input  logic        istrm_h,
  input  logic        flush_h,
  input  logic        fill_valid_h,
  input  logic [31:0] fill_data_h,
  input  logic [1:0]  fill_off_h,
  output logic        fill_req_h,
  output logic [31:0] ib_data_h,
  output logic [3:0]  ib_count_h,
  output logic        ib_stall_h
);

  logic [7:0]  mem [8];
  logic [2:0]  head;
  logic [3:0]  count;

  logic [1:0]  isize_h;
  logic [3:0]  need;
  logic [3:0]  avail;
  logic [3:0]  fill_len;
  logic [3:0]  used;
  logic [3:0]  next_count;
  logic [2:0]  next_head;
  logic [2:0]  wr_base;
  logic        accept;
  logic        consume;
  logic [31:0] stored_data;

  assign isize_h = ~isize_l;

  always_comb begin
    need = 4'd0;
    if (istrm_h) begin
      case (isize_h)
        2'b01:   need = 4'd1;
        2'b10:   need = 4'd2;
        2'b11:   need = 4'd4;
        default: need = 4'd0;
      endcase
    end
  end

  assign fill_req_h = (count <= 4'd4);
  // A fill presented while reset is held is never taken.
  assign accept     = reset_l & fill_valid_h & (fill_req_h | flush_h);
  assign fill_len   = 4'd4 - {2'b00, fill_off_h};

`ifdef IB_BYPASS_EN
  logic bypass;
  assign bypass = (count == 4'd0) & accept;
  assign avail  = bypass ? fill_len : count;
`else
  assign avail  = count;
`endif

  assign ib_stall_h = (need > avail);
  assign consume    = ~ib_stall_h & ~flush_h;
  assign used       = consume ? need : 4'd0;

  // Fill lands behind the pre-consume tail; flush restarts the ring at zero.
  assign wr_base    = flush_h ? 3'd0 : head + count[2:0];
  assign next_head  = flush_h ? 3'd0 : head + used[2:0];
  assign next_count = (flush_h ? 4'd0 : count - used) + (accept ? fill_len : 4'd0);

  always_ff @(posedge clk_h or negedge reset_l) begin
    if (!reset_l) begin
      head  <= 3'd0;
      count <= 4'd0;
      for (int i = 0; i < 8; i++) mem[i] <= 8'h00;
    end else begin
      head  <= next_head;
      count <= next_count;
      if (accept) begin
        for (int j = 0; j < 4; j++) begin
          if (j >= int'(fill_off_h))
            mem[wr_base + 3'(j - int'(fill_off_h))] <= fill_data_h[8*j +: 8];
        end
      end
    end
  end

  always_comb begin
    stored_data = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      if (4'(k) < count) stored_data[8*k +: 8] = mem[head + 3'(k)];
    end
  end

`ifdef IB_BYPASS_EN
  assign ib_data_h = bypass ? (fill_data_h >> {fill_off_h, 3'b000}) : stored_data;
`else
  assign ib_data_h = stored_data;
`endif

  assign ib_count_h = count;

endmodule
